// File: rtl/frame_streamer_if.sv
// Memory-read and pixel-stream bundle between frame_streamer (master) and
// the frame memory plus downstream consumer (slave).
interface frame_streamer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 14
);
  logic                    mem_rd_en;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [3*DATA_WIDTH-1:0] mem_rdata;
  logic                    sink_ready;
  logic                    shift_en;
  logic [3*DATA_WIDTH-1:0] data_out;
  logic                    sof;

  modport master (
    output mem_rd_en, mem_addr, shift_en, data_out, sof,
    input  mem_rdata, sink_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, shift_en, data_out, sof,
    output mem_rdata, sink_ready
  );
endinterface

// File: rtl/frame_streamer.sv
// Streams one raster-order RGB frame from a synchronous-read memory, then
// appends FLUSH_CYCLES zero pixels to drain the downstream window, then pulses done.
module frame_streamer #(
  parameter int WIDTH        = 100,
  parameter int HEIGHT       = 100,
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 14,
  parameter int FLUSH_CYCLES = 202
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  frame_streamer_if.master bus
);
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int FCW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(NPIX - 1);
  localparam logic [FCW-1:0]        FLUSH_LAST = FCW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, STREAM, FLUSH, DRAIN, DONE} state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] addr, addr_nx, last_addr;
  logic [FCW-1:0]        flush_cnt, flush_nx;
  logic                  issue, rd;
  logic                  rd_q, shift_q, sof_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      flush_cnt <= '0;
      last_addr <= '0;
      rd_q      <= 1'b0;
      shift_q   <= 1'b0;
      sof_q     <= 1'b0;
    end else begin
      state     <= state_nx;
      addr      <= addr_nx;
      flush_cnt <= flush_nx;
      if (rd) last_addr <= addr;
      rd_q      <= rd;
      shift_q   <= issue;
      sof_q     <= rd && (addr == '0);
    end
  end

  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    flush_nx = flush_cnt;
    issue    = ((state == STREAM) || (state == FLUSH)) && bus.sink_ready;
    rd       = issue && (state == STREAM);
    case (state)
      IDLE:   if (start) state_nx = STREAM;
      STREAM: if (issue) begin
                if (addr == ADDR_LAST) begin
                  addr_nx  = '0;
                  state_nx = (FLUSH_CYCLES == 0) ? DRAIN : FLUSH;
                end else begin
                  addr_nx = addr + 1'b1;
                end
              end
      FLUSH:  if (issue) begin
                if (flush_cnt == FLUSH_LAST) begin
                  flush_nx = '0;
                  state_nx = DRAIN;
                end else begin
                  flush_nx = flush_cnt + 1'b1;
                end
              end
      DRAIN:  state_nx = DONE;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Address bus holds the last issued address between reads.
  assign bus.mem_rd_en = rd;
  assign bus.mem_addr  = rd ? addr : last_addr;
  assign bus.shift_en  = shift_q;
  assign bus.sof       = sof_q;
  assign bus.data_out  = rd_q ? bus.mem_rdata : '0;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
endmodule

// File: tb/tb_frame_streamer.sv
// Checks two 4x3 streamers (flush 2 and flush 0) against a slot-counting model
// plus literal cycle expectations for the directed scenarios.
module tb_frame_streamer;
  localparam int NPIX = 12;
  localparam int HL   = 512;

  logic clk = 1'b0;
  logic rst;
  logic sr;
  logic st[2];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  frame_streamer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(14)) bus_a ();
  frame_streamer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(14)) bus_b ();

  logic        busy_w[2], done_w[2], rd_w[2], shift_w[2], sof_w[2];
  logic [13:0] addr_w[2];
  logic [23:0] data_w[2];

  frame_streamer #(.WIDTH(4), .HEIGHT(3), .DATA_WIDTH(8), .ADDR_WIDTH(14), .FLUSH_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .start(st[0]), .busy(busy_w[0]), .done(done_w[0]), .bus(bus_a.master));
  frame_streamer #(.WIDTH(4), .HEIGHT(3), .DATA_WIDTH(8), .ADDR_WIDTH(14), .FLUSH_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .start(st[1]), .busy(busy_w[1]), .done(done_w[1]), .bus(bus_b.master));

  assign bus_a.sink_ready = sr;
  assign bus_b.sink_ready = sr;
  assign rd_w[0] = bus_a.mem_rd_en;   assign rd_w[1] = bus_b.mem_rd_en;
  assign addr_w[0] = bus_a.mem_addr;  assign addr_w[1] = bus_b.mem_addr;
  assign shift_w[0] = bus_a.shift_en; assign shift_w[1] = bus_b.shift_en;
  assign data_w[0] = bus_a.data_out;  assign data_w[1] = bus_b.data_out;
  assign sof_w[0] = bus_a.sof;        assign sof_w[1] = bus_b.sof;

  function automatic logic [23:0] word(int a);
    logic [23:0] t;
    t = 24'(a);
    return t * 24'h010203;
  endfunction

  function automatic int total(int i);
    return NPIX + ((i == 0) ? 2 : 0);
  endfunction

  always @(posedge clk) begin
    if (bus_a.mem_rd_en) bus_a.mem_rdata <= word(int'(bus_a.mem_addr));
    if (bus_b.mem_rd_en) bus_b.mem_rdata <= word(int'(bus_b.mem_addr));
  end

  // Model: a frame is a run of total(i) issue slots; slot k is pixel k or a zero.
  bit          m_act[2];
  int          m_n[2], m_post[2], m_last[2];
  bit          e_sh[2], e_sof[2];
  logic [23:0] e_dat[2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] <= 1'b0; m_n[i] <= 0; m_post[i] <= 0; m_last[i] <= 0;
        e_sh[i] <= 1'b0; e_sof[i] <= 1'b0; e_dat[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit ci;
        ci = m_act[i] && (m_n[i] < total(i)) && sr;
        e_sh[i]  <= ci;
        e_sof[i] <= ci && (m_n[i] == 0);
        e_dat[i] <= (ci && m_n[i] < NPIX) ? word(m_n[i]) : 24'h0;
        if (ci && m_n[i] < NPIX) m_last[i] <= m_n[i];
        if (!m_act[i]) begin
          if (st[i]) begin m_act[i] <= 1'b1; m_n[i] <= 0; m_post[i] <= 0; end
        end else if (ci) begin
          m_n[i] <= m_n[i] + 1;
          if (m_n[i] + 1 == total(i)) m_post[i] <= 1;
        end else if (m_post[i] > 0) begin
          m_post[i] <= m_post[i] + 1;
          if (m_post[i] == 2) m_act[i] <= 1'b0;
        end
      end
    end
  end

  task automatic chk(string nm, int i, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s[%0d] cyc %0d: got %0h want %0h", nm, i, cyc, got, want);
    end
  endtask

  bit rd_h[2][HL], sh_h[2][HL], sof_h[2][HL], done_h[2][HL], busy_h[2][HL];
  int addr_h[2][HL];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic er;
      int   ea;
      er = m_act[i] && (m_n[i] < NPIX) && sr;
      ea = er ? m_n[i] : m_last[i];
      chk("busy", i, 32'(busy_w[i]), 32'(m_act[i]));
      chk("done", i, 32'(done_w[i]), 32'(m_act[i] && m_post[i] == 2));
      chk("mem_rd_en", i, 32'(rd_w[i]), 32'(er));
      chk("mem_addr", i, 32'(addr_w[i]), ea);
      chk("shift_en", i, 32'(shift_w[i]), 32'(e_sh[i]));
      chk("data_out", i, 32'(data_w[i]), 32'(e_dat[i]));
      chk("sof", i, 32'(sof_w[i]), 32'(e_sof[i]));
      if (cyc < HL) begin
        rd_h[i][cyc] <= rd_w[i];     sh_h[i][cyc] <= shift_w[i];
        sof_h[i][cyc] <= sof_w[i];   done_h[i][cyc] <= done_w[i];
        busy_h[i][cyc] <= busy_w[i]; addr_h[i][cyc] <= int'(addr_w[i]);
      end
    end
  end

  function automatic bit hv(int k, int i, int c);
    case (k)
      0: return rd_h[i][c];
      1: return sh_h[i][c];
      2: return sof_h[i][c];
      3: return done_h[i][c];
      default: return busy_h[i][c];
    endcase
  endfunction

  function automatic int cnt(int k, int i, int b, int lo, int hi);
    int s = 0;
    for (int c = b + lo; c <= b + hi; c++) if (c >= 0 && c < HL && hv(k, i, c)) s++;
    return s;
  endfunction

  function automatic int first(int k, int i, int b, int lo, int hi);
    for (int c = b + lo; c <= b + hi; c++) if (c >= 0 && c < HL && hv(k, i, c)) return c - b;
    return -1;
  endfunction

  function automatic int last(int k, int i, int b, int lo, int hi);
    for (int c = b + hi; c >= b + lo; c--) if (c >= 0 && c < HL && hv(k, i, c)) return c - b;
    return -1;
  endfunction

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  int b;

  initial begin
    rst = 1'b1; sr = 1'b1; st[0] = 1'b0; st[1] = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);
    chk("lit_rst_busy", 0, 32'(busy_w[0]), 0);
    chk("lit_rst_addr", 0, 32'(addr_w[0]), 0);

    // Full frame on both; A also sees ignored starts at rel 5 and in its DONE cycle.
    b = cyc; st[0] = 1'b1; st[1] = 1'b1;
    tick(1); st[0] = 1'b0; st[1] = 1'b0;
    tick(4); st[0] = 1'b1;
    tick(1); st[0] = 1'b0;
    tick(10); st[0] = 1'b1;
    tick(1); st[0] = 1'b0;
    tick(1);
    chk("lit_s1_first_rd", 0, first(0, 0, b, 0, 17), 1);
    chk("lit_s1_last_rd", 0, last(0, 0, b, 0, 17), 12);
    chk("lit_s1_first_shift", 0, first(1, 0, b, 0, 17), 2);
    chk("lit_s1_last_shift", 0, last(1, 0, b, 0, 17), 15);
    chk("lit_s1_nshift", 0, cnt(1, 0, b, 0, 17), 14);
    chk("lit_s1_sof", 0, first(2, 0, b, 0, 17), 2);
    chk("lit_s1_nsof", 0, cnt(2, 0, b, 0, 17), 1);
    chk("lit_s1_done", 0, first(3, 0, b, 0, 17), 16);
    chk("lit_s1_busy_first", 0, first(4, 0, b, 0, 17), 1);
    chk("lit_s1_busy_last", 0, last(4, 0, b, 0, 17), 16);
    chk("lit_s6_nshift", 1, cnt(1, 1, b, 0, 17), 12);
    chk("lit_s6_last_shift", 1, last(1, 1, b, 0, 17), 13);
    chk("lit_s6_done", 1, first(3, 1, b, 0, 17), 14);
    chk("lit_s6_ndone", 1, cnt(3, 1, b, 0, 17), 1);

    // New frame from idle with sink_ready low for rel 4..6.
    b = cyc; st[0] = 1'b1;
    tick(1); st[0] = 1'b0;
    tick(3); sr = 1'b0;
    tick(3); sr = 1'b1;
    tick(15);
    chk("lit_s2_restart_addr", 0, addr_h[0][b + 1], 0);
    chk("lit_s2_rd_stalled", 0, cnt(0, 0, b, 4, 6), 0);
    chk("lit_s2_shift4", 0, cnt(1, 0, b, 4, 4), 1);
    chk("lit_s2_shift56", 0, cnt(1, 0, b, 5, 6), 0);
    chk("lit_s2_resume_addr", 0, addr_h[0][b + 7], 3);
    chk("lit_s2_nrd", 0, cnt(0, 0, b, 0, 21), 12);
    chk("lit_s2_nshift", 0, cnt(1, 0, b, 0, 21), 14);
    chk("lit_s2_done", 0, first(3, 0, b, 0, 21), 19);

    // Reset while address 5 is being issued.
    b = cyc; st[0] = 1'b1; st[1] = 1'b1;
    tick(1); st[0] = 1'b0; st[1] = 1'b0;
    tick(5);
    chk("lit_s5_addr5", 0, 32'(addr_w[0]), 5);
    rst = 1'b1;
    #1;
    chk("lit_s5_rst_shift", 0, 32'(shift_w[0]), 0);
    chk("lit_s5_rst_rd", 0, 32'(rd_w[0]), 0);
    chk("lit_s5_rst_busy", 0, 32'(busy_w[0]), 0);
    chk("lit_s5_rst_addr", 0, 32'(addr_w[0]), 0);
    tick(2); rst = 1'b0;
    tick(3);
    chk("lit_s5_no_trail", 0, cnt(1, 0, b, 6, 10), 0);
    b = cyc; st[0] = 1'b1; st[1] = 1'b1;
    tick(1); st[0] = 1'b0; st[1] = 1'b0;
    tick(18);
    chk("lit_s5_replay_addr", 0, addr_h[0][b + 1], 0);
    chk("lit_s5_replay_sof", 0, first(2, 0, b, 0, 17), 2);
    chk("lit_s5_replay_nshift", 0, cnt(1, 0, b, 0, 17), 14);
    chk("lit_s5_replay_done", 0, first(3, 0, b, 0, 17), 16);
    chk("lit_s5_replay_nshift", 1, cnt(1, 1, b, 0, 17), 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
